// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT butterfly sequencer.
//   fft_seq_state_t : sequencer state encoding
//   N / HALF_N      : default FFT length and butterflies per stage
//   TW_W            : twiddle ROM word width (Q1.12, 14 bits)
//   fft_addr_w()    : address width for a given log2(N)
//   fft_stage_w()   : width of the stage index for a given log2(N)
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_seq_state_t;

  localparam int LOG2N_DEF = 4;
  localparam int N         = 1 << LOG2N_DEF;
  localparam int HALF_N    = N / 2;
  localparam int TW_W      = 14;

  function automatic int fft_addr_w(input int log2n);
    return log2n;
  endfunction

  // Stage index runs 0..log2n-1; never narrower than one bit.
  function automatic int fft_stage_w(input int log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

endpackage

// File: rtl/fft_wr_delay_line.sv
// Write-back delay line: carries {valid, addr_a, addr_b} for DEPTH cycles so
// the write strobe lines up with the butterfly datapath result.
//   i_clk, i_rst_n          : clock, synchronous active-low reset (clears all)
//   i_valid, i_addr_a/b     : butterfly issued this cycle and its read addresses
//   o_valid, o_addr_a/b     : same butterfly, DEPTH cycles later
module fft_wr_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  output logic          o_valid,
  output logic [AW-1:0] o_addr_a,
  output logic [AW-1:0] o_addr_b
);

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_addr_a [DEPTH];
  logic [AW-1:0]    r_addr_b [DEPTH];

  // The datapath cannot stall, so this line shifts every cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_a[i] <= '0;
        r_addr_b[i] <= '0;
      end
    end else begin
      r_valid[0]  <= i_valid;
      r_addr_a[0] <= i_addr_a;
      r_addr_b[0] <= i_addr_b;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i]  <= r_valid[i-1];
        r_addr_a[i] <= r_addr_a[i-1];
        r_addr_b[i] <= r_addr_b[i-1];
      end
    end
  end

  assign o_valid  = r_valid[DEPTH-1];
  assign o_addr_a = r_addr_a[DEPTH-1];
  assign o_addr_b = r_addr_b[DEPTH-1];

endmodule

// File: rtl/fft_bfly_sequencer.sv
// Radix-2 in-place DIF FFT butterfly sequencer. Issues read-address pairs and
// twiddle pointers stage by stage, delays the addresses for write-back, and
// drains the datapath between stages so no stage reads ahead of the last.
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_start             : start a full pass (only seen in IDLE)
//   i_stall             : hold off butterfly issue this cycle
//   o_busy, o_done      : ISSUE/DRAIN indicator, one-cycle completion pulse
//   o_stage             : current stage index
//   o_bfly_valid        : read addresses / twiddle pointer valid
//   o_rd_addr_a/b       : upper/lower leg read addresses
//   o_rd_ptr_angle      : twiddle index k, angle = -2*pi*k/N
//   o_wr_en, o_wr_addr_a/b : delayed write-back strobe and addresses
//
// state | meaning
// IDLE  | waiting for i_start
// ISSUE | one butterfly per unstalled cycle, k = 0..N/2-1
// DRAIN | BFLY_LAT cycles for in-flight writes to retire (stage barrier)
// DONE  | one-cycle o_done pulse
module fft_bfly_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N    = LOG2N_DEF,
  parameter int BFLY_LAT = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic                            i_stall,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [fft_stage_w(LOG2N)-1:0]   o_stage,
  output logic                            o_bfly_valid,
  output logic [LOG2N-1:0]                o_rd_addr_a,
  output logic [LOG2N-1:0]                o_rd_addr_b,
  output logic [LOG2N-2:0]                o_rd_ptr_angle,
  output logic                            o_wr_en,
  output logic [LOG2N-1:0]                o_wr_addr_a,
  output logic [LOG2N-1:0]                o_wr_addr_b
);

  localparam int AW       = fft_addr_w(LOG2N);
  localparam int SW       = fft_stage_w(LOG2N);
  localparam int KW       = AW - 1;
  localparam int DW       = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam int L_HALF_N = (1 << LOG2N) / 2;

  fft_seq_state_t r_state, w_state_nxt;
  logic [KW-1:0]  r_k, w_k_nxt;
  logic [SW-1:0]  r_s, w_s_nxt;
  logic [DW-1:0]  r_cnt, w_cnt_nxt;
  logic [AW-1:0]  r_addr_a, r_addr_b, w_addr_a, w_addr_b;
  logic [KW-1:0]  r_ptr, w_ptr;
  logic [AW-1:0]  w_kx, w_lo_mask, w_j;
  logic [SW-1:0]  w_pos;
  logic           w_issue;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_s     <= w_s_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_s_nxt     = r_s;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = ISSUE;
          w_k_nxt     = '0;
          w_s_nxt     = '0;
        end
      end
      ISSUE: begin
        if (!i_stall) begin
          if (r_k == KW'(L_HALF_N - 1)) begin
            w_state_nxt = DRAIN;
            w_k_nxt     = '0;
            w_cnt_nxt   = DW'(BFLY_LAT - 1);
          end else begin
            w_k_nxt = r_k + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Down-counter: leave on terminal count, giving exactly BFLY_LAT cycles.
        if (r_cnt == '0) begin
          if (r_s == SW'(LOG2N - 1)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ISSUE;
            w_s_nxt     = r_s + 1'b1;
            w_k_nxt     = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_s_nxt     = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // DIF addressing: rd_addr_a is k with a zero inserted at bit (LOG2N-1-s),
  // rd_addr_b sets that bit; j is the part of k below the inserted bit.
  // Computed from next-state k/s so the registered outputs line up with ISSUE.
  always_comb begin
    w_pos     = SW'(LOG2N - 1) - w_s_nxt;
    w_kx      = AW'(w_k_nxt);
    w_lo_mask = (AW'(1) << w_pos) - AW'(1);
    w_j       = w_kx & w_lo_mask;
    w_addr_a  = ((w_kx & ~w_lo_mask) << 1) | w_j;
    w_addr_b  = w_addr_a | (AW'(1) << w_pos);
    w_ptr     = KW'(w_j << w_s_nxt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_ptr    <= '0;
    end else if (w_state_nxt == ISSUE) begin
      r_addr_a <= w_addr_a;
      r_addr_b <= w_addr_b;
      r_ptr    <= w_ptr;
    end else if (w_state_nxt == IDLE) begin
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_ptr    <= '0;
    end
  end

  assign w_issue = (r_state == ISSUE) && !i_stall;

  fft_wr_delay_line #(
    .DEPTH (BFLY_LAT),
    .AW    (AW)
  ) u_wr_delay (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (w_issue),
    .i_addr_a (r_addr_a),
    .i_addr_b (r_addr_b),
    .o_valid  (o_wr_en),
    .o_addr_a (o_wr_addr_a),
    .o_addr_b (o_wr_addr_b)
  );

  assign o_busy         = (r_state == ISSUE) || (r_state == DRAIN);
  assign o_done         = (r_state == DONE);
  assign o_stage        = r_s;
  assign o_bfly_valid   = w_issue;
  assign o_rd_addr_a    = r_addr_a;
  assign o_rd_addr_b    = r_addr_b;
  assign o_rd_ptr_angle = r_ptr;

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
module tb_fft_bfly_sequencer;
  localparam int LOG2N = 4;
  localparam int LAT   = 3;
  localparam int NN    = 16;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, done, bfly_valid, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] rd_ptr_angle;

  fft_bfly_sequencer #(.LOG2N(LOG2N), .BFLY_LAT(LAT)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_stall        (stall),
    .o_busy         (busy),
    .o_done         (done),
    .o_stage        (stage),
    .o_bfly_valid   (bfly_valid),
    .o_rd_addr_a    (rd_addr_a),
    .o_rd_addr_b    (rd_addr_b),
    .o_rd_ptr_angle (rd_ptr_angle),
    .o_wr_en        (wr_en),
    .o_wr_addr_a    (wr_addr_a),
    .o_wr_addr_b    (wr_addr_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Event log of one pass, cycles relative to the start-pulse cycle.
  bit log_en = 1'b0;
  int base = 0;
  int snap_rel = -1;
  int snap_sum = 0;
  int mon_rel;
  int iss_c[64], iss_s[64], iss_a[64], iss_b[64], iss_p[64];
  int n_iss;
  int wr_c[64], wr_a[64], wr_b[64];
  int n_wr;
  int busy_n, busy_first, busy_last, done_n, done_c;

  always @(negedge clk) begin
    if (log_en) begin
      mon_rel = cyc - base;
      if (bfly_valid) begin
        if (n_iss < 64) begin
          iss_c[n_iss] = mon_rel;
          iss_s[n_iss] = int'(stage);
          iss_a[n_iss] = int'(rd_addr_a);
          iss_b[n_iss] = int'(rd_addr_b);
          iss_p[n_iss] = int'(rd_ptr_angle);
        end
        n_iss++;
      end
      if (wr_en) begin
        if (n_wr < 64) begin
          wr_c[n_wr] = mon_rel;
          wr_a[n_wr] = int'(wr_addr_a);
          wr_b[n_wr] = int'(wr_addr_b);
        end
        n_wr++;
      end
      if (busy) begin
        if (busy_n == 0) busy_first = mon_rel;
        busy_last = mon_rel;
        busy_n++;
      end
      if (done) begin
        done_n++;
        done_c = mon_rel;
      end
      if (mon_rel == snap_rel)
        snap_sum = int'(busy) + int'(done) + int'(bfly_valid) + int'(wr_en) + int'(stage)
                 + int'(rd_addr_a) + int'(rd_addr_b) + int'(rd_ptr_angle)
                 + int'(wr_addr_a) + int'(wr_addr_b);
    end
  end

  // Reference addressing straight from the DIF formulas.
  function automatic int mdl_a(input int s, input int k);
    int span, g, j;
    span = NN >> (s + 1);
    g    = k >> (LOG2N - 1 - s);
    j    = k & (span - 1);
    return 2 * g * span + j;
  endfunction

  function automatic int mdl_p(input int s, input int k);
    int span, j;
    span = NN >> (s + 1);
    j    = k & (span - 1);
    return (j << s) & (HALF - 1);
  endfunction

  function automatic int pk(input int a, input int b, input int p);
    return (a << 16) | (b << 8) | p;
  endfunction

  task automatic do_run(input int stall_at, input int stall_len, input int extra_at, input int rst_at);
    n_iss = 0; n_wr = 0; busy_n = 0; busy_first = -1; busy_last = -1;
    done_n = 0; done_c = -1; snap_sum = 0;
    snap_rel = (rst_at >= 0) ? rst_at + 1 : -1;
    @(posedge clk); #1;
    base = cyc;
    log_en = 1'b1;
    start = 1'b1;
    for (int r = 1; r <= 70; r++) begin
      @(posedge clk); #1;
      start = (r == extra_at);
      stall = (r >= stall_at) && (r < stall_at + stall_len);
      rst_n = !(r == rst_at);
    end
    log_en = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic check_pass(input string tag, input int stall_at, input int stall_len);
    int bad, ec, ea, eb, ep, s, k, cover_bad;
    int hits[4][16];
    bad = 0;
    cover_bad = 0;
    foreach (hits[i, j]) hits[i][j] = 0;
    chk({tag, "_n_iss"}, n_iss, 32);
    chk({tag, "_n_wr"}, n_wr, 32);
    for (int i = 0; i < 32; i++) begin
      s  = i / HALF;
      k  = i % HALF;
      ec = 1 + s * (HALF + LAT) + k;
      if (stall_len > 0 && ec >= stall_at) ec += stall_len;
      ea = mdl_a(s, k);
      eb = ea + (NN >> (s + 1));
      ep = mdl_p(s, k);
      if (iss_c[i] != ec || iss_s[i] != s || iss_a[i] != ea || iss_b[i] != eb || iss_p[i] != ep)
        bad++;
      if (wr_c[i] != ec + LAT || wr_a[i] != ea || wr_b[i] != eb)
        bad++;
      hits[s][wr_a[i] & 15]++;
      hits[s][wr_b[i] & 15]++;
    end
    foreach (hits[i, j]) if (hits[i][j] != 1) cover_bad++;
    chk({tag, "_seq"}, bad, 0);
    chk({tag, "_wr_once"}, cover_bad, 0);
    chk({tag, "_done_n"}, done_n, 1);
    chk({tag, "_done_c"}, done_c, 45 + stall_len);
    chk({tag, "_busy_n"}, busy_n, 44 + stall_len);
    chk({tag, "_busy_first"}, busy_first, 1);
    chk({tag, "_busy_last"}, busy_last, 44 + stall_len);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(bfly_valid), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_stage", int'(stage), 0);
    chk("rst_rd_a", int'(rd_addr_a), 0);
    chk("rst_rd_b", int'(rd_addr_b), 0);
    chk("rst_ptr", int'(rd_ptr_angle), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain pass.
    do_run(-1, 0, -1, -1);
    check_pass("plain", -1, 0);
    chk("s0_k0_cyc", iss_c[0], 1);
    chk("s0_k0", pk(iss_a[0], iss_b[0], iss_p[0]), pk(0, 8, 0));
    chk("s0_k1", pk(iss_a[1], iss_b[1], iss_p[1]), pk(1, 9, 1));
    chk("s0_k7", pk(iss_a[7], iss_b[7], iss_p[7]), pk(7, 15, 7));
    chk("wr0_cyc", wr_c[0], 4);
    chk("wr0", pk(wr_a[0], wr_b[0], 0), pk(0, 8, 0));
    chk("s1_k0", pk(iss_a[8], iss_b[8], iss_p[8]), pk(0, 4, 0));
    chk("s1_k1", pk(iss_a[9], iss_b[9], iss_p[9]), pk(1, 5, 2));
    chk("s1_k4", pk(iss_a[12], iss_b[12], iss_p[12]), pk(8, 12, 0));
    chk("s3_k5", pk(iss_a[29], iss_b[29], iss_p[29]), pk(10, 11, 0));
    chk("barrier_gap", iss_c[8] - wr_c[7], 1);

    // Extra start while busy must be ignored.
    do_run(-1, 0, 5, -1);
    check_pass("xstart", -1, 0);

    // Five-cycle stall in the middle of stage 2 (issue cycles 23..30).
    do_run(25, 5, -1, -1);
    check_pass("stall", 25, 5);
    cnt = 0;
    for (int i = 0; i < 32; i++) if (iss_c[i] >= 25 && iss_c[i] <= 29) cnt++;
    chk("stall_no_issue", cnt, 0);
    chk("stall_k1_cyc", iss_c[17], 24);
    chk("stall_k2_cyc", iss_c[18], 30);

    // Reset asserted in stage 1 DRAIN (cycles 20..22), sampled at end of 21.
    do_run(-1, 0, -1, 21);
    chk("rst_mid_outputs", snap_sum, 0);
    cnt = 0;
    for (int i = 0; i < n_wr && i < 64; i++) if (wr_c[i] >= 22) cnt++;
    chk("rst_mid_late_wr", cnt, 0);
    chk("rst_mid_n_wr", n_wr, 15);
    chk("rst_mid_done", done_n, 0);
    chk("rst_mid_busy_last", busy_last, 21);

    // Fresh pass after the interrupted one.
    do_run(-1, 0, -1, -1);
    check_pass("after_rst", -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
